// File: rtl/cordic_pkg.sv
// Shared constants and the tag payload for the CORDIC arbiter slice.
package cordic_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDW     = $clog2(NREQ);
  localparam int unsigned NORM    = 20;
  localparam int unsigned LAT     = 17;
  localparam int unsigned CREDITS = 4;

  // Credit counter and blanking counter widths.
  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned BW = $clog2(LAT + 1);

  // Angle encoding: 0x40000 is a quarter turn.
  localparam logic [NORM-1:0] NUM_90  = 20'h40000;
  localparam logic [NORM-1:0] NUM_180 = 20'h80000;
  localparam logic [NORM:0]   NUM_360 = 21'h100000;

  // Requester tag carried alongside an operation in flight.
  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_arbiter_rr_pick.sv
// Round-robin priority search: first eligible requester at or after ptr.
module rr_pick
  import cordic_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            hit
);

  logic [IDW-1:0] cand;

  // Walk the requesters from ptr, wrapping, and take the first eligible one.
  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!hit && eligible[cand]) begin
        hit         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined vectoring CORDIC between NREQ requesters with credits.
module cordic_arbiter
  import cordic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NORM-1:0] req_x,
  input  logic [NREQ*NORM-1:0] req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [NORM-1:0]      cor_x,
  output logic [NORM-1:0]      cor_y,
  output logic                 cor_valid,
  input  logic [NORM-1:0]      cor_res_x,
  input  logic [NORM-1:0]      cor_res_z,
  input  logic                 cor_res_valid,
  output logic [NREQ-1:0]      res_valid,
  output logic [NORM-1:0]      res_mag,
  output logic [NORM-1:0]      res_ang,
  input  logic [NREQ-1:0]      res_ack,
  output logic                 busy,
  output logic                 err
);

  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   credit [NREQ];
  tag_t            tags [LAT+1];
  tag_t            tag_out;
  logic [BW-1:0]   blank;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack_err;
  logic [IDW-1:0]  gidx;
  logic            ghit;

  // A requester may win only with a pending request and buffer space; never in reset.
  always_comb begin
    eligible = '0;
    ack_err  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (credit[i] != '0) && !rst;
      ack_err[i]  = res_ack[i] && (credit[i] == CW'(CREDITS));
    end
  end

  rr_pick u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx      (gidx),
    .hit      (ghit)
  );

  assign req_ready = grant;

  // Operand issue and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cor_valid <= 1'b0;
      cor_x     <= '0;
      cor_y     <= '0;
    end else begin
      cor_valid <= ghit;
      if (ghit) begin
        rr_ptr <= IDW'((32'(gidx) + 1) % NREQ);
        cor_x  <= req_x[32'(gidx)*NORM +: NORM];
        cor_y  <= req_y[32'(gidx)*NORM +: NORM];
      end
    end
  end

  // Per-requester credits; an ack into a full counter is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) credit[i] <= CW'(CREDITS);
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i] && !(res_ack[i] && !ack_err[i]))
          credit[i] <= credit[i] - CW'(1);
        else if (!grant[i] && res_ack[i] && !ack_err[i])
          credit[i] <= credit[i] + CW'(1);
      end
    end
  end

  // Tag shift register: stage 0 runs with cor_valid, stage LAT with cor_res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s <= LAT; s++) tags[s] <= '0;
    end else begin
      tags[0] <= tag_t'{valid: ghit, id: gidx};
      for (int unsigned s = 1; s <= LAT; s++) tags[s] <= tags[s-1];
    end
  end

  assign tag_out = tags[LAT];

  // Any tag still travelling through the CORDIC.
  always_comb begin
    busy = 1'b0;
    for (int unsigned s = 0; s <= LAT; s++) busy = busy | tags[s].valid;
  end

  // Result routing, post-reset blanking and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= '0;
      res_mag   <= '0;
      res_ang   <= '0;
      err       <= 1'b0;
      blank     <= BW'(LAT);
    end else begin
      res_valid <= '0;
      if (blank != '0) blank <= blank - BW'(1);
      if (tag_out.valid && cor_res_valid) begin
        res_valid[tag_out.id] <= 1'b1;
        res_mag               <= cor_res_x;
        res_ang               <= cor_res_z;
      end
      if ((|ack_err) || ((blank == '0) && (tag_out.valid != cor_res_valid)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency fake CORDIC.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*NORM-1:0] req_x;
  logic [NREQ*NORM-1:0] req_y;
  logic [NREQ-1:0]      req_ready;
  logic [NORM-1:0]      cor_x;
  logic [NORM-1:0]      cor_y;
  logic                 cor_valid;
  logic [NORM-1:0]      cor_res_x;
  logic [NORM-1:0]      cor_res_z;
  logic                 cor_res_valid;
  logic [NREQ-1:0]      res_valid;
  logic [NORM-1:0]      res_mag;
  logic [NORM-1:0]      res_ang;
  logic [NREQ-1:0]      res_ack;
  logic                 busy;
  logic                 err;

  int tests = 0;
  int fails = 0;
  int late  = 0;
  logic fake_clr;
  logic [NREQ-1:0] ack_mask;

  cordic_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .cor_x(cor_x), .cor_y(cor_y), .cor_valid(cor_valid),
    .cor_res_x(cor_res_x), .cor_res_z(cor_res_z), .cor_res_valid(cor_res_valid),
    .res_valid(res_valid), .res_mag(res_mag), .res_ang(res_ang), .res_ack(res_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Fake CORDIC: magnitude = x, angle = y, LAT cycles (or LAT+1 when late); ignores rst.
  logic            fv [LAT+1];
  logic [NORM-1:0] fx [LAT+1];
  logic [NORM-1:0] fz [LAT+1];
  always @(posedge clk) begin
    if (fake_clr) begin
      for (int s = 0; s <= LAT; s++) begin fv[s] <= 1'b0; fx[s] <= '0; fz[s] <= '0; end
    end else begin
      fv[0] <= cor_valid; fx[0] <= cor_x; fz[0] <= cor_y;
      for (int s = 1; s <= LAT; s++) begin fv[s] <= fv[s-1]; fx[s] <= fx[s-1]; fz[s] <= fz[s-1]; end
    end
  end
  assign cor_res_valid = (late != 0) ? fv[LAT]   : fv[LAT-1];
  assign cor_res_x     = (late != 0) ? fx[LAT]   : fx[LAT-1];
  assign cor_res_z     = (late != 0) ? fz[LAT]   : fz[LAT-1];

  task automatic step();
    @(negedge clk);
    res_ack = res_valid & ack_mask;
  endtask

  task automatic set_req(input int i, input logic [NORM-1:0] x, input logic [NORM-1:0] y);
    req_x[i*NORM +: NORM] = x;
    req_y[i*NORM +: NORM] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; res_ack = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; res_ack = '0;
    step(); step();
    #1;
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tests++; if (cor_valid !== 1'b0 || cor_x !== '0 || cor_y !== '0) begin fails++; $display("FAIL reset_cor: got v=%b x=%h y=%h want 0", cor_valid, cor_x, cor_y); end
    tests++; if (res_valid !== '0 || res_mag !== '0 || res_ang !== '0) begin fails++; $display("FAIL reset_res: got v=%b m=%h a=%h want 0", res_valid, res_mag, res_ang); end
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", busy, err); end
    tests++; if (dut.credit[0] !== 3'd4 || dut.credit[1] !== 3'd4 || dut.credit[2] !== 3'd4 || dut.credit[3] !== 3'd4) begin
      fails++; $display("FAIL reset_credit: got %0d %0d %0d %0d want 4 4 4 4", dut.credit[0], dut.credit[1], dut.credit[2], dut.credit[3]);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    int n;
    do_reset(); ack_mask = '0;
    set_req(2, 20'h00100, 20'h0);
    req_valid = 4'b0100; #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step(); req_valid = '0;
    tests++; if (cor_valid !== 1'b1 || cor_x !== 20'h00100 || cor_y !== 20'h0) begin fails++; $display("FAIL single_issue: got v=%b x=%h y=%h want 1 00100 00000", cor_valid, cor_x, cor_y); end
    tests++; if (dut.credit[2] !== 3'd3) begin fails++; $display("FAIL single_credit_dec: got %0d want 3", dut.credit[2]); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    n = 1;
    while (res_valid === '0 && n < 40) begin step(); n++; end
    tests++; if (n != 19) begin fails++; $display("FAIL single_latency: got %0d want 19", n); end
    tests++; if (res_valid !== 4'b0100 || res_mag !== 20'h00100 || res_ang !== 20'h0) begin
      fails++; $display("FAIL single_result: got v=%b m=%h a=%h want 0100 00100 00000", res_valid, res_mag, res_ang);
    end
    res_ack = 4'b0100;
    step();
    tests++; if (dut.credit[2] !== 3'd4) begin fails++; $display("FAIL single_credit_ret: got %0d want 4", dut.credit[2]); end
    tests++; if (res_valid !== '0 || busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL single_idle: got v=%b busy=%b err=%b want 0 0 0", res_valid, busy, err); end
  endtask

  task automatic test_rotate();
    int got, n;
    do_reset(); ack_mask = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, NORM'(32'h11 * (i + 1)), NORM'(i));
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      tests++; if (req_ready !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rotate_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
      step();
      tests++; if (cor_valid !== 1'b1) begin fails++; $display("FAIL rotate_cor_valid%0d: got %b want 1", k, cor_valid); end
    end
    req_valid = '0;
    got = 0; n = 0;
    while (got < 16 && n < 60) begin
      if (res_valid !== '0) begin
        tests++;
        if (res_valid !== 4'(1 << (got % 4)) || res_mag !== NORM'(32'h11 * (got % 4 + 1)) || res_ang !== NORM'(got % 4)) begin
          fails++; $display("FAIL rotate_result%0d: got v=%b m=%h a=%h want %b %h %h", got, res_valid, res_mag, res_ang,
                            4'(1 << (got % 4)), NORM'(32'h11 * (got % 4 + 1)), NORM'(got % 4));
        end
        got++;
      end
      step(); n++;
    end
    tests++; if (got != 16) begin fails++; $display("FAIL rotate_count: got %0d want 16", got); end
    step(); step();
    tests++; if (busy !== 1'b0 || err !== 1'b0 || dut.credit[0] !== 3'd4 || dut.credit[3] !== 3'd4) begin
      fails++; $display("FAIL rotate_end: got busy=%b err=%b c0=%0d c3=%0d want 0 0 4 4", busy, err, dut.credit[0], dut.credit[3]);
    end
  endtask

  task automatic test_starve();
    int g1, gother, multi;
    do_reset(); ack_mask = 4'b1101;
    for (int i = 0; i < NREQ; i++) set_req(i, NORM'(i + 5), NORM'(i));
    req_valid = '1;
    g1 = 0; gother = 0; multi = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!$onehot0(req_ready)) multi++;
      if (req_ready[1]) g1++; else if (req_ready !== '0) gother++;
      step();
    end
    tests++; if (g1 != 4) begin fails++; $display("FAIL starve_grants1: got %0d want 4", g1); end
    tests++; if (gother < 20) begin fails++; $display("FAIL starve_others: got %0d want >=20", gother); end
    tests++; if (multi != 0) begin fails++; $display("FAIL starve_onehot: got %0d multi-grant cycles want 0", multi); end
    res_ack = res_ack | 4'b0010;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready[1]) g1++;
      step();
    end
    tests++; if (g1 != 5) begin fails++; $display("FAIL starve_regrant: got %0d want 5", g1); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL starve_err: got %b want 0", err); end
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset(); ack_mask = '0;
    set_req(0, 20'h00ABC, 20'h00DEF);
    req_valid = 4'b0001; #1;
    step(); req_valid = '0;
    n = 1;
    while (res_valid[0] !== 1'b1 && n < 40) begin step(); n++; end
    tests++; if (res_valid !== 4'b0001 || res_mag !== 20'h00ABC || res_ang !== 20'h00DEF) begin
      fails++; $display("FAIL same_result: got v=%b m=%h a=%h want 0001 00abc 00def", res_valid, res_mag, res_ang);
    end
    req_valid = 4'b0001; res_ack = 4'b0001; #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL same_ready: got %b want 0001", req_ready); end
    step(); req_valid = '0;
    tests++; if (dut.credit[0] !== 3'd3) begin fails++; $display("FAIL same_credit: got %0d want 3", dut.credit[0]); end
    res_ack = 4'b0001; step();
    tests++; if (dut.credit[0] !== 3'd4 || err !== 1'b0) begin fails++; $display("FAIL same_ack: got c=%0d err=%b want 4 0", dut.credit[0], err); end
    res_ack = 4'b0001; step();
    tests++; if (err !== 1'b1 || dut.credit[0] !== 3'd4) begin fails++; $display("FAIL over_ack: got err=%b c=%0d want 1 4", err, dut.credit[0]); end
    for (int k = 0; k < 5; k++) step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    int stray, n;
    do_reset(); ack_mask = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, NORM'(32'h100 + i), NORM'(i));
    req_valid = '1;
    for (int k = 0; k < 5; k++) step();
    req_valid = '0;
    step(); step(); step();
    rst = 1'b1; req_valid = '1; #1;
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL mid_ready_in_rst: got %b want 0000", req_ready); end
    step(); rst = 1'b0; req_valid = '0;
    tests++; if (busy !== 1'b0 || cor_valid !== 1'b0) begin fails++; $display("FAIL mid_flush: got busy=%b cor_valid=%b want 0 0", busy, cor_valid); end
    tests++; if (dut.credit[0] !== 3'd4 || dut.credit[1] !== 3'd4 || dut.credit[2] !== 3'd4 || dut.credit[3] !== 3'd4) begin
      fails++; $display("FAIL mid_credit: got %0d %0d %0d %0d want 4 4 4 4", dut.credit[0], dut.credit[1], dut.credit[2], dut.credit[3]);
    end
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      if (res_valid !== '0) stray++;
      step();
    end
    tests++; if (stray != 0) begin fails++; $display("FAIL mid_stray: got %0d results want 0", stray); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", err); end
    set_req(3, 20'h12345, 20'h0ABCD);
    req_valid = 4'b1000; #1;
    step(); req_valid = '0;
    n = 1;
    while (res_valid === '0 && n < 40) begin step(); n++; end
    tests++; if (n != 19 || res_valid !== 4'b1000 || res_mag !== 20'h12345 || res_ang !== 20'h0ABCD) begin
      fails++; $display("FAIL mid_after: got n=%0d v=%b m=%h a=%h want 19 1000 12345 0abcd", n, res_valid, res_mag, res_ang);
    end
  endtask

  task automatic test_late();
    int rv;
    do_reset(); ack_mask = '1;
    for (int k = 0; k < 20; k++) step();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL late_pre_err: got %b want 0", err); end
    late = 1;
    set_req(0, 20'h00777, 20'h00111);
    req_valid = 4'b0001; #1;
    step(); req_valid = '0;
    rv = 0;
    for (int k = 0; k < 30; k++) begin
      if (res_valid !== '0) rv++;
      step();
    end
    tests++; if (rv != 0) begin fails++; $display("FAIL late_result: got %0d results want 0", rv); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL late_err: got %b want 1", err); end
    late = 0;
  endtask

  initial begin
    fake_clr = 1'b1; rst = 1'b1; ack_mask = '0;
    req_valid = '0; req_x = '0; req_y = '0; res_ack = '0;
    test_reset();
    fake_clr = 1'b0;
    test_single();
    test_rotate();
    test_starve();
    test_same_cycle();
    test_reset_mid();
    test_late();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
